// File: rtl/passage_detector_pkg.sv
// Shared definitions for the lane passage detector: FSM state encoding,
// (beam_out, beam_in) pair encodings and the debounce counter width.
package passage_detector_pkg;

  localparam int CNT_W   = 8;
  localparam int STALL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E1    = 3'd1,
    ST_E2    = 3'd2,
    ST_E3    = 3'd3,
    ST_X1    = 3'd4,
    ST_X2    = 3'd5,
    ST_X3    = 3'd6,
    ST_ABORT = 3'd7
  } state_e;

  // Filtered beam pair, packed as {beam_out, beam_in}
  localparam logic [1:0] PAIR_CLEAR = 2'b00;
  localparam logic [1:0] PAIR_IN    = 2'b01;
  localparam logic [1:0] PAIR_OUT   = 2'b10;
  localparam logic [1:0] PAIR_BOTH  = 2'b11;

  // True for the six phases of a passage in progress
  function automatic logic in_passage(input state_e s);
    return (s != ST_IDLE) && (s != ST_ABORT);
  endfunction

endpackage

// File: rtl/passage_detector_beam_debounce.sv
// Two-flop synchronizer followed by a consecutive-difference debounce
// counter. The filtered output follows the synchronized beam once the two
// have disagreed for DEB_CYCLES consecutive cycles.
module beam_debounce
  import passage_detector_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; any agreement restarts the count
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, filtered value and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/passage_detector.sv
// Lane passage detector: debounces the street-side and lot-side beams and
// walks the four-phase blocking sequence to emit one-cycle entry/exit pulses.
// Optional feature macro: PASSAGE_TIMEOUT_EN adds a stall counter that aborts
// a passage stuck in one phase for TIMEOUT_CYCLES cycles.
module passage_detector
  import passage_detector_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_out,
  input  logic beam_in,
  output logic sensor_ent,
  output logic sensor_sai,
  output logic busy,
  output logic fault
);

  localparam logic [STALL_W-1:0] TIMEOUT_LIM = STALL_W'(TIMEOUT_CYCLES);

  logic       out_filt, in_filt;
  logic [1:0] pair;

  state_e state_q, state_d;
  logic   ent_q, ent_d;
  logic   sai_q, sai_d;
  logic   busy_q, fault_q;
  logic   timed_out;

  beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_out (
    .clk   (clk),
    .reset (reset),
    .raw   (beam_out),
    .filt  (out_filt)
  );

  beam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_in (
    .clk   (clk),
    .reset (reset),
    .raw   (beam_in),
    .filt  (in_filt)
  );

  assign pair = {out_filt, in_filt};

`ifdef PASSAGE_TIMEOUT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall counter: restarts on IDLE or any phase change, saturates otherwise
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      stall_d = '0;
    end else if (stall_q != {STALL_W{1'b1}}) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign timed_out = in_passage(state_q) && (stall_q >= TIMEOUT_LIM);
`else
  logic [STALL_W-1:0] timeout_unused;
  assign timeout_unused = TIMEOUT_LIM;
  assign timed_out      = 1'b0;
`endif

  // Next-state and pulse decode from the filtered beam pair
  always_comb begin
    state_d = state_q;
    ent_d   = 1'b0;
    sai_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (pair)
          PAIR_OUT:  state_d = ST_E1;
          PAIR_IN:   state_d = ST_X1;
          PAIR_BOTH: state_d = ST_ABORT;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_E1: begin
        case (pair)
          PAIR_BOTH:  state_d = ST_E2;
          PAIR_CLEAR: state_d = ST_IDLE;
          PAIR_IN:    state_d = ST_ABORT;
          default:    state_d = ST_E1;
        endcase
      end
      ST_E2: begin
        case (pair)
          PAIR_IN:    state_d = ST_E3;
          PAIR_OUT:   state_d = ST_E1;
          PAIR_CLEAR: state_d = ST_ABORT;
          default:    state_d = ST_E2;
        endcase
      end
      ST_E3: begin
        case (pair)
          PAIR_CLEAR: begin
            state_d = ST_IDLE;
            ent_d   = 1'b1;
          end
          PAIR_BOTH: state_d = ST_E2;
          PAIR_OUT:  state_d = ST_ABORT;
          default:   state_d = ST_E3;
        endcase
      end
      ST_X1: begin
        case (pair)
          PAIR_BOTH:  state_d = ST_X2;
          PAIR_CLEAR: state_d = ST_IDLE;
          PAIR_OUT:   state_d = ST_ABORT;
          default:    state_d = ST_X1;
        endcase
      end
      ST_X2: begin
        case (pair)
          PAIR_OUT:   state_d = ST_X3;
          PAIR_IN:    state_d = ST_X1;
          PAIR_CLEAR: state_d = ST_ABORT;
          default:    state_d = ST_X2;
        endcase
      end
      ST_X3: begin
        case (pair)
          PAIR_CLEAR: begin
            state_d = ST_IDLE;
            sai_d   = 1'b1;
          end
          PAIR_BOTH: state_d = ST_X2;
          PAIR_IN:   state_d = ST_ABORT;
          default:   state_d = ST_X3;
        endcase
      end
      default: begin
        if (pair == PAIR_CLEAR) state_d = ST_IDLE;
        else                    state_d = ST_ABORT;
      end
    endcase

    // A stalled passage is abandoned without a pulse
    if (timed_out) begin
      state_d = ST_ABORT;
      ent_d   = 1'b0;
      sai_d   = 1'b0;
    end
  end

  // FSM state and registered outputs; busy/fault decode the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ent_q   <= 1'b0;
      sai_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      sai_q   <= sai_d;
      busy_q  <= (state_d != ST_IDLE);
      fault_q <= (state_d == ST_ABORT);
    end
  end

  assign sensor_ent = ent_q;
  assign sensor_sai = sai_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_passage_detector.sv
// Scoreboard bench for passage_detector (DEB_CYCLES=4, TIMEOUT_CYCLES=50).
// Stimulus pushes expected pulses (kind + edge number); a monitor pops and
// compares whenever the DUT raises sensor_ent or sensor_sai.
module tb_passage_detector;

  localparam int DEB = 4;
  localparam int TMO = 50;
  localparam int PULSE_LAT = DEB + 3;

  typedef struct {
    bit is_ent;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic beam_out = 1'b0;
  logic beam_in = 1'b0;
  logic sensor_ent, sensor_sai, busy, fault;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  passage_detector #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .beam_out   (beam_out),
    .beam_in    (beam_in),
    .sensor_ent (sensor_ent),
    .sensor_sai (sensor_sai),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset && (sensor_ent || sensor_sai)) begin
      exp_t e;
      check("pulse_exclusive", int'(sensor_ent && sensor_sai), 0);
      check("busy_at_pulse", int'(busy), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_ent", int'(sensor_ent), int'(e.is_ent));
        check("pulse_edge", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic o, input logic i);
    @(negedge clk);
    beam_out = o;
    beam_in  = i;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Final release: expect a pulse PULSE_LAT edges after the first sampling edge
  task automatic release_expect(input bit is_ent);
    exp_t e;
    drive(1'b0, 1'b0);
    e.is_ent = is_ent;
    e.cyc    = cyc + PULSE_LAT;
    exp_q.push_back(e);
    hold(12);
  endtask

  task automatic check_status(input string name, input logic b, input logic f);
    check({name, "_busy"}, int'(busy), int'(b));
    check({name, "_fault"}, int'(fault), int'(f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    hold(2);
    check("rst_ent", int'(sensor_ent), 0);
    check("rst_sai", int'(sensor_sai), 0);
    check_status("rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    hold(3);

    // Clean entry
    drive(1'b1, 1'b0); hold(10);
    check_status("ent_e1", 1'b1, 1'b0);
    drive(1'b1, 1'b1); hold(10);
    drive(1'b0, 1'b1); hold(10);
    release_expect(1'b1);
    check_status("ent_done", 1'b0, 1'b0);

    // Clean exit
    drive(1'b0, 1'b1); hold(10);
    drive(1'b1, 1'b1); hold(10);
    drive(1'b1, 1'b0); hold(10);
    check_status("sai_x3", 1'b1, 1'b0);
    release_expect(1'b0);
    check_status("sai_done", 1'b0, 1'b0);

    // Back-out with short glitches on beam_in while in E1
    drive(1'b1, 1'b0); hold(10);
    for (int g = 0; g < 3; g++) begin
      drive(1'b1, 1'b1); hold(2);
      drive(1'b1, 1'b0); hold(5);
    end
    check_status("glitch_e1", 1'b1, 1'b0);
    drive(1'b0, 1'b0); hold(10);
    check_status("backout", 1'b0, 1'b0);

    // Sequence violation E1 -> (0,1)
    drive(1'b1, 1'b0); hold(10);
    drive(1'b0, 1'b1); hold(10);
    check_status("viol_abort", 1'b1, 1'b1);
    drive(1'b0, 1'b0); hold(10);
    check_status("viol_clear", 1'b0, 1'b0);

    // Reset mid-passage in E2, released with both beams still blocked
    drive(1'b1, 1'b0); hold(10);
    drive(1'b1, 1'b1); hold(10);
    check_status("pre_rst_e2", 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    hold(2);
    check("midrst_ent", int'(sensor_ent), 0);
    check("midrst_sai", int'(sensor_sai), 0);
    check_status("midrst", 1'b0, 1'b0);
    reset = 1'b1;
    hold(10);
    check_status("post_rst_abort", 1'b1, 1'b1);
    drive(1'b0, 1'b0); hold(10);
    check_status("post_rst_idle", 1'b0, 1'b0);

    // Long stall in E2
    drive(1'b1, 1'b0); hold(10);
    drive(1'b1, 1'b1);
`ifdef PASSAGE_TIMEOUT_EN
    hold(DEB + 3 + TMO);
    check("stall_pre_timeout_fault", int'(fault), 0);
    hold(1);
    check("stall_timeout_fault", int'(fault), 1);
    hold(2);
    drive(1'b0, 1'b0); hold(10);
    check_status("stall_cleared", 1'b0, 1'b0);
`else
    hold(60);
    check_status("stall_e2", 1'b1, 1'b0);
    drive(1'b0, 1'b1); hold(10);
    release_expect(1'b1);
    check_status("stall_done", 1'b0, 1'b0);
`endif

    hold(5);
    check("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/passage_detector.md
# passage_detector

Lane-level vehicle passage detector for the parking entrance/exit lane. It takes two raw, bouncy infrared beam inputs, beam_out on the street side and beam_in on the lot side. It debounces them and tracks the four-phase blocking sequence to decide the direction of travel. It then emits single-cycle `sensor_ent` / `sensor_sai` pulses that drive the existing entry/exit monitor, which in turn feeds the occupancy counter.

## Interface
- DEB_CYCLES, 4, consecutive stable cycles before a beam's filtered value changes (range 1..255)
- TIMEOUT_CYCLES, 1000, max cycles a passage may stall in one phase (only used with timeout enabled; 16-bit)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- beam_out  in  1  raw street-side beam, 1 = blocked; asynchronous to clk
- beam_in  in  1  raw lot-side beam, 1 = blocked; asynchronous to clk
- sensor_ent  out  1  one-cycle pulse, complete entry detected
- sensor_sai  out  1  one-cycle pulse, complete exit detected
- busy  out  1  FSM not in IDLE
- fault  out  1  high while in ABORT

## Operation
- Each beam input passes through a 2-FF synchronizer and then a debounce counter.
  - The filtered value takes the synchronized value once they have differed for DEB_CYCLES consecutive cycles.
  - Any agreement between the two clears the counter.
- Direction FSM on filtered (o,i) = (beam_out, beam_in). States: IDLE, E1, E2, E3, X1, X2, X3, ABORT.
- IDLE transitions:
  - (1,0) -> E1
  - (0,1) -> X1
  - (1,1) -> ABORT
  - (0,0) stays IDLE
- Entry path:
  - E1: (1,1)->E2; (0,0)->IDLE with no pulse (car backed out); (0,1)->ABORT.
  - E2: (0,1)->E3; (1,0)->E1; (0,0)->ABORT.
  - E3: (0,0)->IDLE and assert sensor_ent; (1,1)->E2; (1,0)->ABORT.
- Exit path: X1..X3 mirror E1..E3 with o and i swapped. X3->IDLE on (0,0) asserts sensor_sai.
- ABORT: stay until (0,0), then IDLE. No pulse is ever emitted from ABORT.
- sensor_ent and sensor_sai are registered.
  - Each is high for exactly one cycle.
  - They are never high together.
  - Two pulses are always separated by at least DEB_CYCLES+1 low cycles, because a new passage must pass through E1/X1. The downstream monitor therefore counts each passage exactly once.
- Reset values: sensor_ent=0, sensor_sai=0, busy=0, fault=0, FSM=IDLE, filtered beams=0, synchronizers=0, debounce counters=0.
- Reset mid-passage: the passage is discarded with no pulse. After release:
  - a still-blocked beam is re-debounced and enters E1/X1;
  - both beams blocked enter ABORT.

## Timing
- Filter latency: a raw change that stays stable is reflected in the filtered value 2+DEB_CYCLES rising edges after the first edge that samples it.
- The FSM registers the transition on the following edge. A clean final beam release therefore produces its pulse in the cycle starting DEB_CYCLES+3 edges after the first sampling edge.
- Glitches shorter than DEB_CYCLES cycles (post-sync) never reach the FSM.
- Simultaneous filtered change of both beams is evaluated as a single (o,i) pair per the transition rules above, with no priority ordering.
- busy and fault are registered decodes of the next state; they change on the same edge as the state.

## Configuration
- PASSAGE_TIMEOUT_EN defined:
  - A 16-bit stall counter clears on IDLE and on any state change, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES in E1..E3 or X1..X3, the FSM enters ABORT (fault=1) on the next edge.
  - The counter saturates; it does not wrap.
- Undefined: no stall counter is built. The FSM may wait in any phase indefinitely, and fault rises only for sequence violations.

## Structure
- Shared package: FSM state encoding (3-bit localparams IDLE..ABORT) and the (o,i) beam-pair encodings used in transitions.
- Sub-module `beam_debounce`: synchronizer plus counter, parameterized by DEB_CYCLES, instantiated twice.
- FSM, output registers and optional stall counter live in passage_detector.

## Test plan
Parameters: DEB_CYCLES=4, TIMEOUT_CYCLES=50.
- Clean entry: raw (o,i) = (1,0),(1,1),(0,1),(0,0), each held 10 cycles -> exactly one sensor_ent pulse, 7 edges after the final release is first sampled; sensor_sai stays 0.
- Clean exit: (0,1),(1,1),(1,0),(0,0), 10 cycles each -> exactly one sensor_sai pulse; busy falls on the same edge as the pulse.
- Back-out: (1,0) for 10 cycles, then (0,0) -> no pulse; busy returns to 0. Also, 3-cycle glitches on beam_in during (1,0) -> state remains E1.
- Sequence violation: (1,0) then (0,1) -> fault=1; (0,0) -> fault=0; no pulses.
- Reset mid-passage: reset low for 2 cycles while in E2 -> all outputs 0. Release with (1,1) held -> ABORT, fault=1; then (0,0) -> IDLE; no pulse.
- PASSAGE_TIMEOUT_EN defined: hold (1,1) in E2 for 60 cycles -> fault rises 51 edges after E2 entry. Without the macro, the same stimulus leaves fault=0 and state E2.
